// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter that frame WIDTH-bit words from the serial stream.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             sync,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic             busy
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sr_next = sr;
        if (MSB_FIRST) begin
            sr_next = {sr[WIDTH-2:0], ser_in};
        end else begin
            sr_next = {ser_in, sr[WIDTH-1:1]};
        end
    end

    // The completed word is the value sr is about to take, so the buffer can
    // capture it on the same edge that samples the last bit.
    assign word      = sr_next;
    assign word_done = ser_en && !sync && (cnt == LAST);
    assign busy      = (cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (sync) begin
            sr  <= '0;
            cnt <= '0;
        end else if (ser_en) begin
            sr  <= sr_next;
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: one-entry output buffer with valid/ready handshake and sticky overrun.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    logic [WIDTH-1:0] word;
    logic             word_done;
    buf_state_t       buf_state;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_en    (ser_en),
        .sync      (sync),
        .word      (word),
        .word_done (word_done),
        .busy      (busy)
    );

    assign out_valid = (buf_state == BUF_FULL);

    // word_done is already masked by sync, so clearing and setting overrun never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_state <= BUF_EMPTY;
            data_out  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (sync) begin
                overrun <= 1'b0;
            end
            if (word_done) begin
                if (buf_state == BUF_EMPTY || out_ready) begin
                    data_out  <= word;
                    buf_state <= BUF_FULL;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (buf_state == BUF_FULL && out_ready) begin
                buf_state <= BUF_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser with a word scoreboard checked at every handshake.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_bit, ser_en, sync, out_ready;
    logic       loop_mode, piso_load;
    logic [3:0] piso_din, piso_q;
    logic       ser_in;

    logic [3:0] data_out, data_out_lsb;
    logic       out_valid, overrun, busy;
    logic       out_valid_lsb, overrun_lsb, busy_lsb;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] rnd_word;

    always #5 clk = ~clk;

    // Reference 4-bit PISO transmitter, MSB first.
    always @(posedge clk) begin
        if (rst) piso_q <= 4'd0;
        else if (piso_load) piso_q <= piso_din;
        else if (loop_mode && ser_en) piso_q <= {piso_q[2:0], 1'b0};
    end

    assign ser_in = loop_mode ? piso_q[3] : ser_bit;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_en    (ser_en),
        .sync      (sync),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_en    (ser_en),
        .sync      (sync),
        .data_out  (data_out_lsb),
        .out_valid (out_valid_lsb),
        .out_ready (out_ready),
        .overrun   (overrun_lsb),
        .busy      (busy_lsb)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, score any handshake that completes on this edge, sample 1 after.
    task automatic step(input logic b, input logic en, input logic rdy, input logic sy);
        ser_bit   = b;
        ser_en    = en;
        out_ready = rdy;
        sync      = sy;
        #2;
        if (out_valid && out_ready) begin
            check("sb_pending", 8'(exp_q.size() != 0), 8'd1);
            if (exp_q.size() != 0) check("sb_data", 8'(data_out), 8'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    // Stream w[3] first; rdy_last applies on the bit that completes the word.
    task automatic send_word(input logic [3:0] w, input logic rdy, input logic rdy_last);
        for (int i = 3; i >= 0; i--) step(w[i], 1'b1, (i == 0) ? rdy_last : rdy, 1'b0);
    endtask

    task automatic piso_word(input logic [3:0] v);
        piso_din  = v;
        piso_load = 1'b1;
        loop_mode = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        piso_load = 1'b0;
        loop_mode = 1'b1;
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
        loop_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ser_bit = 1'b0; ser_en = 1'b0; sync = 1'b0; out_ready = 1'b0;
        loop_mode = 1'b0; piso_load = 1'b0; piso_din = 4'd0;
        @(posedge clk); #1;
        check("rst_data",    8'(data_out),  8'h0);
        check("rst_valid",   8'(out_valid), 8'h0);
        check("rst_overrun", 8'(overrun),   8'h0);
        check("rst_busy",    8'(busy),      8'h0);
        check("rst_valid_lsb", 8'(out_valid_lsb), 8'h0);
        rst = 1'b0;

        // Reset mid-word
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("mid_busy", 8'(busy), 8'h1);
        rst = 1'b1;
        #1;
        check("midrst_busy",  8'(busy),      8'h0);
        check("midrst_valid", 8'(out_valid), 8'h0);
        check("midrst_data",  8'(data_out),  8'h0);
        #1 rst = 1'b0;
        exp_q.push_back(4'b0110);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("w3_valid", 8'(out_valid), 8'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("w4_data",  8'(data_out),  8'h6);
        check("w4_valid", 8'(out_valid), 8'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("drain_valid", 8'(out_valid), 8'h0);

        // Loopback from the PISO transmitter
        exp_q.push_back(4'b0110);
        piso_word(4'b0110);
        check("loop1_data", 8'(data_out), 8'h6);
        exp_q.push_back(4'b0111);
        piso_word(4'b0111);
        check("loop2_data",    8'(data_out), 8'h7);
        check("loop2_overrun", 8'(overrun),  8'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: second word is dropped
        exp_q.push_back(4'b0110);
        send_word(4'b0110, 1'b0, 1'b0);
        check("bp1_data", 8'(data_out), 8'h6);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("bp7_overrun", 8'(overrun), 8'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("bp8_data",    8'(data_out),  8'h6);
        check("bp8_valid",   8'(out_valid), 8'h1);
        check("bp8_overrun", 8'(overrun),   8'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_drain_valid", 8'(out_valid), 8'h0);
        check("bp_sticky",      8'(overrun),   8'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sync_clr_overrun", 8'(overrun), 8'h0);

        // Drain and complete on the same edge
        exp_q.push_back(4'b0110);
        send_word(4'b0110, 1'b0, 1'b0);
        exp_q.push_back(4'b1001);
        send_word(4'b1001, 1'b0, 1'b1);
        check("simul_data",    8'(data_out),  8'h9);
        check("simul_valid",   8'(out_valid), 8'h1);
        check("simul_overrun", 8'(overrun),   8'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Sync discards a partial word and the bit presented with it
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("sync_busy", 8'(busy), 8'h0);
        exp_q.push_back(4'b1010);
        send_word(4'b1010, 1'b0, 1'b0);
        check("sync_data", 8'(data_out), 8'hA);
        check("sync_busy_after", 8'(busy), 8'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sync_full_data",  8'(data_out),  8'hA);
        check("sync_full_valid", 8'(out_valid), 8'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Bit order: same stream into both instances
        step(1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(4'b1100);
        send_word(4'b1100, 1'b0, 1'b0);
        check("msb_data",  8'(data_out),      8'hC);
        check("lsb_data",  8'(data_out_lsb),  8'h3);
        check("lsb_valid", 8'(out_valid_lsb), 8'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back words with out_ready tied high
        for (int k = 0; k < 6; k++) begin
            rnd_word = 4'($urandom_range(0, 15));
            exp_q.push_back(rnd_word);
            send_word(rnd_word, 1'b1, 1'b1);
            check("tput_valid", 8'(out_valid), 8'h1);
        end
        check("tput_overrun", 8'(overrun), 8'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("end_valid",  8'(out_valid),    8'h0);
        check("sb_empty",   8'(exp_q.size()), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
